ripple_count_monitor: RTL
=========================

// Module: ripple_count_monitor
// PURPOSE
//  Downstream consumer of the 4-bit JK ripple counter. Resynchronises the counter's
//  asynchronous, rippling Q outputs into the system clock domain. Rejects transient
//  ripple states with a stability filter. Extends the count with a wrap counter.
//  Publishes each new settled value over a valid/ready interface.
// PARAMETERS
//  WIDTH          4  width of ripple counter Q bus
//  EXT_W          4  width of wrap-extension counter (upper bits of count_out)
//  STABLE_CYCLES  2  consecutive equal synchronised samples to accept a value (>=1)
// PORTS
//  clock        in   1              system clock, rising edge
//  reset        in   1              asynchronous, active-high reset
//  q_in         in   WIDTH          raw ripple counter outputs (Q[WIDTH-1:0]), asynchronous
//  count_ready  in   1              consumer ready; transfer when count_valid & count_ready
//  count_out    out  WIDTH+EXT_W    {ext_count, last_stable}
//  count_valid  out  1              count_out holds an untransferred value
//  wrap_pulse   out  1              one-cycle pulse when a wrap is detected
//  overrun      out  1              sticky: unread value was overwritten
//  delta        out  WIDTH          only when RCM_DELTA_EN is defined
// BEHAVIOUR
//  Reset: all flops and outputs are 0. This includes s1, s2, cand, cnt, last_stable,
//   ext_count, count_out, count_valid, wrap_pulse, overrun and delta. Reset asserted
//   mid-operation discards any pending value immediately. It does not wait for an edge.
//  Sync: q_in passes through 2 flops, s1 -> s2. No logic acts on s1.
//  Filter, each edge:
//   - If s2 != cand: cand <= s2 and cnt <= 1.
//   - Else: cnt increments, saturating at STABLE_CYCLES.
//   - Accept fires once, on the edge where cnt reaches STABLE_CYCLES, if cand != last_stable.
//  Value equal to last_stable: no event. A value held < STABLE_CYCLES samples is discarded.
//  Latency: count_valid rises on the (2+STABLE_CYCLES)th edge after q_in settles
//   (setup met). With defaults this is edge 4.
//  On accept:
//   - If cand < last_stable (unsigned), this is a wrap: ext_count <= ext_count+1
//     mod 2^EXT_W, and wrap_pulse = 1 for exactly one cycle.
//   - ext_count rolling over from all-ones to 0 still pulses wrap_pulse.
//   - last_stable <= cand; count_out <= {new ext_count, cand}.
//  Skipped counter values are legal. The counter must advance < 2^WIDTH steps between
//   accepts, otherwise a wrap is missed; this is not detected.
//  FSM IDLE / HOLD:
//   - IDLE: count_valid = 0. On accept, go to HOLD.
//   - HOLD: count_valid = 1 and count_out stable, unless overwritten (see below).
//   - HOLD, count_ready = 1, no accept: transfer, go to IDLE. count_valid low next cycle.
//   - HOLD, count_ready = 1, accept: transfer old value, load new value, stay in HOLD.
//   - HOLD, count_ready = 0, accept: overwrite count_out with newest value, set overrun,
//     stay in HOLD.
//   - overrun clears only on reset.
// CONFIGURATION
//  RCM_DELTA_EN defined:
//   - delta <= (cand - last_stable) mod 2^WIDTH, registered on each accept.
//   - delta is held otherwise. For a wrap 15->1 (WIDTH = 4), delta = 2.
//  RCM_DELTA_EN undefined: the delta port and its logic are absent.
//  Filter, FSM and wrap behaviour are identical in both builds.
// TESTING
//  1. Reset, q_in = 0 for 20 cycles -> all outputs 0; count_valid never rises.
//  2. count_ready = 1; q_in 0->5, held 10 cycles -> count_valid high 1 cycle at edge 4,
//     count_out = 8'h05, no wrap_pulse.
//  3. q_in 5->15->0, each held 10 cycles -> values 8'h0F then 8'h10;
//     wrap_pulse exactly 1 cycle, on the 8'h10 accept.
//  4. q_in = 5 stable; glitch q_in = 3 for 1 cycle -> no accept;
//     count_valid, count_out and wrap_pulse unchanged.
//  5. count_ready = 0; q_in 1 then 2, each held 10 cycles -> count_out = 8'h02 (low nibble 2),
//     overrun = 1. Raise count_ready -> count_valid low next cycle; overrun stays 1.
//  6. Assert reset mid-HOLD between clock edges -> count_valid, count_out and overrun go to 0
//     immediately. With RCM_DELTA_EN, q_in 0->3 after release -> delta = 3.

Source files
------------

// File: rtl/ripple_count_monitor.sv
// -----------------------------------------------------------------------------
// ripple_count_monitor
//
// Consumer of a free-running JK ripple counter. The counter's Q outputs are
// asynchronous and pass through transient codes while bits ripple, so this
// block:
//   1. resynchronises q_in through a two-flop synchroniser (s1 -> s2),
//   2. accepts a value only after STABLE_CYCLES consecutive equal samples,
//   3. extends the count with a wrap counter whenever a new value is
//      numerically smaller than the previous accepted one,
//   4. offers each new settled value on a valid/ready interface, overwriting
//      an unread value (and flagging overrun) if the consumer is slow.
//
// Optional feature (compile-time macro RCM_DELTA_EN):
//   When defined, a 'delta' output carries (new - previous) mod 2^WIDTH,
//   registered on every accept. When undefined the port and logic are absent.
//
// Parameters
//   WIDTH          width of the ripple counter Q bus
//   EXT_W          width of the wrap-extension counter (upper bits of count_out)
//   STABLE_CYCLES  consecutive equal synchronised samples to accept (>= 1)
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   q_in         in   raw ripple counter outputs, asynchronous to clock
//   count_ready  in   consumer ready; transfer when count_valid & count_ready
//   count_out    out  {ext_count, last_stable}
//   count_valid  out  count_out holds an untransferred value
//   wrap_pulse   out  one-cycle pulse on the accept that detects a wrap
//   overrun      out  sticky: an unread value was overwritten (reset clears)
//   delta        out  accepted step size (RCM_DELTA_EN builds only)
// -----------------------------------------------------------------------------
module ripple_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int EXT_W         = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       q_in,
    input  logic                   count_ready,
    output logic [WIDTH+EXT_W-1:0] count_out,
    output logic                   count_valid,
    output logic                   wrap_pulse,
    output logic                   overrun
`ifdef RCM_DELTA_EN
    ,
    output logic [WIDTH-1:0]       delta
`endif
);

    // Counter just wide enough to hold STABLE_CYCLES.
    localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]       r_s1;
    logic [WIDTH-1:0]       r_s2;
    logic [WIDTH-1:0]       r_cand;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_last_stable;
    logic [EXT_W-1:0]       r_ext_count;
    logic [WIDTH+EXT_W-1:0] r_count_out;
    logic                   r_wrap_pulse;
    logic                   r_overrun;
    state_t                 r_state;

    // -------------------------------------------------------------------------
    // Combinational nets
    // -------------------------------------------------------------------------
    logic                   w_new_cand;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_reached;
    logic                   w_accept;
    logic                   w_wrap;
    logic [EXT_W-1:0]       w_ext_next;
    logic                   w_set_overrun;
    state_t                 w_state_next;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. Nothing but r_s2 may look at r_s1: r_s1 can be
    // metastable, and a multi-bit ripple code can be captured half-updated.
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse s1/s2 into
    // a single stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= q_in;
            r_s2 <= r_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Stability filter.
    // r_cand always follows r_s2 one edge late, so r_cnt is the length of the
    // current run of equal synchronised samples, saturating at CNT_MAX.
    // The accept fires only on the edge where the run length first reaches
    // CNT_MAX; a run that merely stays saturated does not re-fire. For
    // STABLE_CYCLES = 1 a fresh candidate reaches the threshold immediately,
    // which is why w_new_cand also qualifies the reach condition.
    // -------------------------------------------------------------------------
    always_comb begin
        w_new_cand = (r_s2 != r_cand);

        if (w_new_cand) begin
            w_cnt_next = CNT_W'(1);
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end

        w_reached = (w_cnt_next == CNT_MAX) && (w_new_cand || (r_cnt != CNT_MAX));

        // The candidate after this edge is r_s2; re-accepting the value
        // already published is suppressed.
        w_accept  = w_reached && (r_s2 != r_last_stable);

        // An up-counter only ever moves to a smaller code by rolling over.
        w_wrap     = w_accept && (r_s2 < r_last_stable);
        w_ext_next = w_wrap ? (r_ext_count + EXT_W'(1)) : r_ext_count;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else begin
            r_cand <= r_s2;
            r_cnt  <= w_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Accept datapath: extension counter, published value, wrap pulse.
    // count_out is loaded on every accept regardless of handshake state; the
    // FSM decides whether that was a normal load or an overwrite.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_stable <= '0;
            r_ext_count   <= '0;
            r_count_out   <= '0;
            r_wrap_pulse  <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_accept) begin
                r_last_stable <= r_s2;
                r_ext_count   <= w_ext_next;
                r_count_out   <= {w_ext_next, r_s2};
            end
        end
    end

`ifdef RCM_DELTA_EN
    // Step size of the accepted value, modulo the counter range, so a
    // roll-over such as 15 -> 1 reports the true forward distance of 2.
    logic [WIDTH-1:0] r_delta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_delta <= '0;
        end else if (w_accept) begin
            r_delta <= r_s2 - r_last_stable;
        end
    end

    assign delta = r_delta;
`endif

    // -------------------------------------------------------------------------
    // Handshake FSM. IDLE: nothing to offer. HOLD: count_out is on offer.
    // An accept in HOLD always lands in HOLD: with ready high the old value
    // transfers on this edge and the new one takes its place; with ready low
    // the old value is lost and overrun is flagged.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_set_overrun = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    w_state_next  = ST_HOLD;
                    w_set_overrun = !count_ready;
                end else if (count_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Sticky overrun; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_set_overrun) begin
            r_overrun <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from flops or a flop decode)
    // -------------------------------------------------------------------------
    assign count_out   = r_count_out;
    assign count_valid = (r_state == ST_HOLD);
    assign wrap_pulse  = r_wrap_pulse;
    assign overrun     = r_overrun;

endmodule
